// File: rtl/arith_pkg.sv
// Shared definitions for the ripple arithmetic family: the default operand
// width and the start/done sequencer states used by the serial datapaths.
package arith_pkg;

    localparam int ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - z with borrow-out bo.
// Mirror image of the full-adder cell used in the combinational ripple adder.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ z;
    assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor: diff = a - b - bin, one bit per clock, LSB
// first, through a single full-subtractor cell with a registered borrow.
// Operands are captured on an accepted start; results appear with a one-cycle
// done pulse and are held until the next completion.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    // The single cell sees the current LSBs of the shifting operands plus the
    // borrow produced by the previous bit position.
    full_subtractor u_cell (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .z  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    assign last_bit = (cnt_q == LAST_CNT);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept start only when idle, leave RUN after the MSB bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so no input reaches them.
    always_comb begin
        busy = (state_q == RUN) || (state_q == DONE);
        done = (state_q == DONE);
    end

    // Datapath next values: capture, shift one bit per cycle, publish at the end.
    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        res_d  = res_q;
        brw_d  = brw_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        ovf_d  = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d  = a;
                    sb_d  = b;
                    brw_d = bin;
                    cnt_d = '0;
                end
            end
            RUN: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                res_d = {cell_d, res_q[WIDTH-1:1]};
                brw_d = cell_bo;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    // brw_q here is the borrow into the MSB cell; signed
                    // overflow is its disagreement with the final borrow.
                    diff_d = {cell_d, res_q[WIDTH-1:1]};
                    bout_d = cell_bo;
                    ovf_d  = brw_q ^ cell_bo;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_q   <= '0;
            sb_q   <= '0;
            res_q  <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            res_q  <= res_d;
            brw_q  <= brw_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
